// File: rtl/decode_scan.sv
// decode_scan: registered one-hot decoder with direct/scan-up/hold/scan-down modes; in W,En,Mode,Load; out Y(onehot),Idx,Wrap(pulse)
module decode_scan #(
  parameter int N = 2,
  parameter int DIV = 4
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic [N-1:0]    W,
  input  logic            En,
  input  logic [1:0]      Mode,
  input  logic            Load,
  output logic [2**N-1:0] Y,
  output logic [N-1:0]    Idx,
  output logic            Wrap
);
  localparam int M = 2**N;
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
  logic [CW-1:0] cnt;
  logic          up;
  logic [N-1:0]  nxt;
  always_comb begin
    up = ~Mode[1];
    nxt = up ? Idx + N'(1) : Idx - N'(1);
  end
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      Y <= '0;
      Idx <= '0;
      cnt <= '0;
      Wrap <= 1'b0;
    end else if (!En) begin
      Y <= '0;
      Wrap <= 1'b0;
    end else if (Mode == 2'b10) begin
      Wrap <= 1'b0;
    end else if (Mode == 2'b00 || Load) begin
      Idx <= W;
      cnt <= '0;
      Y <= M'(1) << W;
      Wrap <= 1'b0;
    end else if (cnt != CMAX) begin
      cnt <= cnt + CW'(1);
      Wrap <= 1'b0;
    end else begin
      cnt <= '0;
      Idx <= nxt;
      Y <= M'(1) << nxt;
      Wrap <= up ? &Idx : ~|Idx;
    end
endmodule

// File: tb/tb_decode_scan.sv
// tb_decode_scan: scoreboard bench for decode_scan over three parameter sets
module tb_decode_scan;
  logic clk, rst_n, en, load;
  logic [1:0] mode;
  logic [2:0] w;
  logic [3:0] y0;
  logic [1:0] idx0;
  logic       wr0;
  logic [1:0] y1;
  logic [0:0] idx1;
  logic       wr1;
  logic [7:0] y2;
  logic [2:0] idx2;
  logic       wr2;
  int tests = 0, fails = 0;
  typedef struct {int i; int y; int idx; int wr;} exp_t;
  exp_t q[$];
  int m_idx[3], m_cnt[3], m_y[3], m_wr[3];

  decode_scan #(.N(2), .DIV(4)) dut0 (.Clock(clk), .Resetn(rst_n), .W(w[1:0]), .En(en), .Mode(mode), .Load(load), .Y(y0), .Idx(idx0), .Wrap(wr0));
  decode_scan #(.N(1), .DIV(1)) dut1 (.Clock(clk), .Resetn(rst_n), .W(w[0:0]), .En(en), .Mode(mode), .Load(load), .Y(y1), .Idx(idx1), .Wrap(wr1));
  decode_scan #(.N(3), .DIV(2)) dut2 (.Clock(clk), .Resetn(rst_n), .W(w), .En(en), .Mode(mode), .Load(load), .Y(y2), .Idx(idx2), .Wrap(wr2));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic int sz(int i);
    return i == 0 ? 4 : i == 1 ? 2 : 8;
  endfunction
  function automatic int dv(int i);
    return i == 0 ? 4 : i == 1 ? 1 : 2;
  endfunction
  function automatic logic [31:0] dy(int i);
    return i == 0 ? {28'd0, y0} : i == 1 ? {30'd0, y1} : {24'd0, y2};
  endfunction
  function automatic logic [31:0] didx(int i);
    return i == 0 ? {30'd0, idx0} : i == 1 ? {31'd0, idx1} : {29'd0, idx2};
  endfunction
  function automatic logic [31:0] dwr(int i);
    return i == 0 ? {31'd0, wr0} : i == 1 ? {31'd0, wr1} : {31'd0, wr2};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_idx[i] = 0; m_cnt[i] = 0; m_y[i] = 0; m_wr[i] = 0;
    end
  endtask

  task automatic model_step();
    int s, wv;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      s = sz(i);
      wv = int'(w) % s;
      if (!en) begin
        m_y[i] = 0; m_wr[i] = 0;
      end else if (mode == 2'b10) begin
        m_wr[i] = 0;
      end else if (mode == 2'b00 || load) begin
        m_idx[i] = wv; m_cnt[i] = 0; m_y[i] = 1 << wv; m_wr[i] = 0;
      end else if (m_cnt[i] < dv(i) - 1) begin
        m_cnt[i]++; m_wr[i] = 0;
      end else begin
        m_cnt[i] = 0;
        if (mode == 2'b01) begin
          m_wr[i] = (m_idx[i] == s - 1) ? 1 : 0;
          m_idx[i] = (m_idx[i] + 1) % s;
        end else begin
          m_wr[i] = (m_idx[i] == 0) ? 1 : 0;
          m_idx[i] = (m_idx[i] + s - 1) % s;
        end
        m_y[i] = 1 << m_idx[i];
      end
      e.i = i; e.y = m_y[i]; e.idx = m_idx[i]; e.wr = m_wr[i];
      q.push_back(e);
    end
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      if (dy(e.i) !== e.y || didx(e.i) !== e.idx || dwr(e.i) !== e.wr) begin
        fails++;
        $display("FAIL scoreboard dut%0d t=%0t: got y=%0h idx=%0d wrap=%0d, expected y=%0h idx=%0d wrap=%0d",
                 e.i, $time, dy(e.i), didx(e.i), dwr(e.i), e.y, e.idx, e.wr);
      end
    end
  endtask

  task automatic check0(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; en = 0; mode = 0; load = 0; w = 0;
    #3;
    for (int i = 0; i < 3; i++) begin
      check0("reset_y", dy(i), 0);
      check0("reset_idx", didx(i), 0);
      check0("reset_wrap", dwr(i), 0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_direct();
    en = 1; mode = 2'b00; w = 3'd2;
    tick();
    check0("direct_w2_y", {28'd0, y0}, 32'b0100);
    check0("direct_w2_idx", {30'd0, idx0}, 2);
    w = 3'd3;
    tick();
    check0("direct_w3_y", {28'd0, y0}, 32'b1000);
    load = 1; w = 3'd1;
    tick();
    check0("direct_load_ignored_y", {28'd0, y0}, 32'b0010);
    load = 0;
  endtask

  task automatic test_scan_up();
    mode = 2'b00; w = 0;
    tick();
    mode = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check0("scan_up_y", {28'd0, y0}, 32'd1 << ((k / 4) % 4));
      check0("scan_up_wrap", {31'd0, wr0}, k == 16 ? 1 : 0);
    end
    tick();
    check0("scan_up_wrap_clear", {31'd0, wr0}, 0);
  endtask

  task automatic test_scan_down();
    mode = 2'b11; load = 1; w = 0;
    tick();
    check0("scan_down_load_y", {28'd0, y0}, 32'b0001);
    load = 0;
    for (int k = 0; k < 4; k++) tick();
    check0("scan_down_y", {28'd0, y0}, 32'b1000);
    check0("scan_down_idx", {30'd0, idx0}, 3);
    check0("scan_down_wrap", {31'd0, wr0}, 1);
    tick();
    check0("scan_down_wrap_clear", {31'd0, wr0}, 0);
  endtask

  task automatic test_hold_en();
    mode = 2'b01;
    for (int k = 0; k < 8 && m_cnt[0] != 2; k++) tick();
    tests++;
    if (m_cnt[0] != 2) begin
      fails++;
      $display("FAIL hold_reach_cnt2: got cnt %0d, expected 2", m_cnt[0]);
    end
    mode = 2'b10;
    for (int k = 0; k < 10; k++) begin
      tick();
      check0("hold_y", {28'd0, y0}, 32'b1000);
      check0("hold_idx", {30'd0, idx0}, 3);
    end
    mode = 2'b01;
    tick();
    check0("resume_no_step_idx", {30'd0, idx0}, 3);
    tick();
    check0("resume_step_idx", {30'd0, idx0}, 0);
    check0("resume_step_wrap", {31'd0, wr0}, 1);
    en = 0;
    tick();
    check0("disable_y", {28'd0, y0}, 0);
    check0("disable_idx", {30'd0, idx0}, 0);
    check0("disable_wrap", {31'd0, wr0}, 0);
  endtask

  task automatic test_async_reset();
    en = 1; mode = 2'b01;
    for (int k = 0; k < 20 && m_idx[0] != 3; k++) tick();
    tick();
    check0("pre_reset_idx", {30'd0, idx0}, 3);
    #2 rst_n = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check0("async_reset_y", dy(i), 0);
      check0("async_reset_idx", didx(i), 0);
      check0("async_reset_wrap", dwr(i), 0);
    end
    model_reset();
    #1 rst_n = 1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check0("post_reset_y", {28'd0, y0}, k == 4 ? 32'b0010 : 0);
      check0("post_reset_wrap", {31'd0, wr0}, 0);
    end
  endtask

  task automatic test_sweep();
    @(negedge clk);
    rst_n = 0;
    #1;
    model_reset();
    rst_n = 1;
    en = 1; mode = 2'b01; load = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check0("n1_idx", {31'd0, idx1}, k % 2);
      check0("n1_y", {30'd0, y1}, 32'd1 << (k % 2));
      check0("n1_wrap", {31'd0, wr1}, (k % 2 == 0) ? 1 : 0);
      check0("n3_idx", {29'd0, idx2}, (k / 2) % 8);
      check0("n3_wrap", {31'd0, wr2}, k == 16 ? 1 : 0);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 400; k++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      load = ($urandom_range(0, 11) == 0);
      w = 3'($urandom_range(0, 7));
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan_up();
    test_scan_down();
    test_hold_en();
    test_async_reset();
    test_sweep();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
